// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: command-side issuer for the logic/compare datapath.
// Requests are queued in a DEPTH-entry FIFO, issued one at a time as a
// registered opcode/operand set, and the result plus EQ/GT/LT flags are
// returned over a valid/ready response channel.
// Optional statistics counters are built when LOGIC_OP_SEQ_STATS_EN is defined;
// otherwise stat_issued/stat_err are tied to zero.
module logic_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [7:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_y,
  input  logic        cmp_eq,
  input  logic        cmp_gt,
  input  logic        cmp_lt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] stat_issued,
  output logic [7:0]  stat_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t          state_reg, state_next;
  logic [19:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            init_done_reg;
  logic            push, pop;
  logic [3:0]      head_op;
  logic [7:0]      head_a, head_b;
  logic            head_legal;
  logic [7:0]      head_opcode;
  logic [7:0]      alu_opcode_reg, alu_a_reg, alu_b_reg;
  logic [7:0]      rsp_data_reg;
  logic [2:0]      rsp_flags_reg;
  logic            rsp_err_reg;

  // cmd_ready stays low through reset and comes up one edge after release
  assign cmd_ready = init_done_reg && (count_reg != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;

  assign head_op     = mem[rd_ptr_reg][19:16];
  assign head_a      = mem[rd_ptr_reg][15:8];
  assign head_b      = mem[rd_ptr_reg][7:0];
  assign head_legal  = (head_op >= 4'd1) && (head_op <= 4'd8);
  // CMP is encoded as 8'h00, logic ops pass their select straight through
  assign head_opcode = (head_op == 4'd8) ? 8'h00 : {4'b0000, head_op};

  // FIFO storage: no reset needed, emptiness is tracked by the count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd_op, cmd_a, cmd_b};
  end

  // FIFO pointers, occupancy and the post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state and FIFO pop decision
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = head_legal ? DRIVE : RESP;
        end
      end
      DRIVE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue registers and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_data_reg   <= '0;
      rsp_flags_reg  <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE && pop) begin
        if (head_legal) begin
          alu_opcode_reg <= head_opcode;
          alu_a_reg      <= head_a;
          alu_b_reg      <= head_b;
        end else begin
          // illegal op: answer directly, leave the datapath untouched
          rsp_data_reg  <= '0;
          rsp_flags_reg <= '0;
          rsp_err_reg   <= 1'b1;
        end
      end else if (state_reg == DRIVE) begin
        rsp_data_reg  <= (alu_opcode_reg == 8'h00) ? {5'b00000, cmp_gt, cmp_eq, cmp_lt} : alu_y;
        rsp_flags_reg <= {cmp_gt, cmp_eq, cmp_lt};
        rsp_err_reg   <= 1'b0;
      end
    end
  end

  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign rsp_flags  = rsp_flags_reg;
  assign rsp_err    = rsp_err_reg;
  assign busy       = (count_reg != '0) || (state_reg != IDLE);

`ifdef LOGIC_OP_SEQ_STATS_EN
  logic [15:0] stat_issued_reg;
  logic [7:0]  stat_err_reg;

  // Saturating counters of legal issues and illegal requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_reg <= '0;
      stat_err_reg    <= '0;
    end else if (state_reg == IDLE && pop) begin
      if (head_legal) begin
        if (stat_issued_reg != 16'hFFFF) stat_issued_reg <= stat_issued_reg + 16'd1;
      end else begin
        if (stat_err_reg != 8'hFF) stat_err_reg <= stat_err_reg + 8'd1;
      end
    end
  end

  assign stat_issued = stat_issued_reg;
  assign stat_err    = stat_err_reg;
`else
  assign stat_issued = '0;
  assign stat_err    = '0;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Testbench for logic_op_sequencer: directed vectors feed a scoreboard queue,
// a monitor pops and compares on every response handshake.
// Statistics checks follow LOGIC_OP_SEQ_STATS_EN.
module tb_logic_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [7:0]  alu_opcode, alu_a, alu_b;
  logic [7:0]  alu_y;
  logic        cmp_eq, cmp_gt, cmp_lt;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
  logic [15:0] stat_issued;
  logic [7:0]  stat_err;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] flags;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic_op_sequencer #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy),
    .stat_issued(stat_issued), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  // Environment: the logic controller and comparators the sequencer drives
  always_comb begin
    alu_y = 8'h00;
    case (alu_opcode)
      8'h01: alu_y = alu_a & alu_b;
      8'h02: alu_y = alu_a | alu_b;
      8'h03: alu_y = alu_a ^ alu_b;
      8'h04: alu_y = ~(alu_a & alu_b);
      8'h05: alu_y = ~(alu_a | alu_b);
      8'h06: alu_y = ~(alu_a ^ alu_b);
      8'h07: alu_y = ~alu_a;
      default: alu_y = 8'h00;
    endcase
  end
  assign cmp_eq = (alu_a == alu_b);
  assign cmp_gt = (alu_a >  alu_b);
  assign cmp_lt = (alu_a <  alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: compare each accepted response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {23'd0, rsp_data, rsp_flags, rsp_err}, 32'hFFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        $display("rsp data=%02h flags=%03b err=%0d (want %02h %03b %0d)",
                 rsp_data, rsp_flags, rsp_err, e.data, e.flags, e.err);
        check("rsp_data",  {24'd0, rsp_data},  {24'd0, e.data});
        check("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flags});
        check("rsp_err",   {31'd0, rsp_err},   {31'd0, e.err});
      end
    end
  end

  // Present one command until accepted (bounded); push its expected response
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic [2:0] ef, input logic ee);
    logic done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        done = 1'b1;
        exp_q.push_back('{data: ed, flags: ef, err: ee});
        $display("cmd op=%0h a=%02h b=%02h", op, a, b);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy && !rsp_valid && exp_q.size() == 0) done = 1'b1;
    end
    check("wait_idle", {31'd0, done}, 32'd1);
  endtask

  // Backpressure table: op, a, b, expected data, flags, err
  logic [3:0] bp_op [8] = '{4'd2, 4'd3, 4'd4, 4'd8, 4'd0, 4'd1, 4'd1, 4'd1};
  logic [7:0] bp_a  [8] = '{8'h01, 8'hFF, 8'hF0, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] bp_b  [8] = '{8'h02, 8'h0F, 8'hF0, 8'h20, 8'h00, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] bp_d  [8] = '{8'h03, 8'hF0, 8'h0F, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF};
  logic [2:0] bp_f  [8] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010};
  logic       bp_e  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int accepted;
    logic seen;

    // Reset: outputs all zero while held
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {8'd0, cmd_ready, rsp_valid, busy, rsp_err, rsp_flags, alu_opcode, alu_a, alu_b} |
          {16'd0, rsp_data, stat_err}, 32'd0);
    check("reset_stat_issued", {16'd0, stat_issued}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_reset_busy",      {31'd0, busy},      32'd0);

    // AND with latency checks
    rsp_ready = 1'b1;
    send(4'd1, 8'hF0, 8'h3C, 8'h30, 3'b100, 1'b0);
    @(posedge clk); #1;
    check("and_drive_opcode", {24'd0, alu_opcode}, 32'h01);
    check("and_drive_a",      {24'd0, alu_a},      32'hF0);
    check("and_valid_low_e1", {31'd0, rsp_valid},  32'd0);
    @(posedge clk); #1;
    check("and_valid_high_e2", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // CMP, greater then equal
    send(4'd8, 8'h80, 8'h7F, 8'h04, 3'b100, 1'b0);
    @(posedge clk); #1;
    check("cmp_drive_opcode", {24'd0, alu_opcode}, 32'h00);
    wait_idle();
    send(4'd8, 8'h55, 8'h55, 8'h02, 3'b010, 1'b0);
    wait_idle();

    // Illegal op: immediate error response, datapath untouched
    send(4'hF, 8'h12, 8'h34, 8'h00, 3'b000, 1'b1);
    @(posedge clk); #1;
    check("illegal_valid_e1", {31'd0, rsp_valid}, 32'd1);
    wait_idle();
    check("illegal_alu_opcode", {24'd0, alu_opcode}, 32'h00);
    check("illegal_alu_a",      {24'd0, alu_a},      32'h55);
    check("illegal_alu_b",      {24'd0, alu_b},      32'h55);
`ifdef LOGIC_OP_SEQ_STATS_EN
    check("stat_err",    {24'd0, stat_err},    32'd1);
    check("stat_issued", {16'd0, stat_issued}, 32'd3);
`else
    check("stat_err",    {24'd0, stat_err},    32'd0);
    check("stat_issued", {16'd0, stat_issued}, 32'd0);
`endif

    // A few more logic ops
    send(4'd7, 8'h0F, 8'h00, 8'hF0, 3'b100, 1'b0);
    send(4'd6, 8'hAA, 8'h55, 8'h00, 3'b100, 1'b0);
    send(4'd5, 8'h00, 8'h01, 8'hFE, 3'b001, 1'b0);
    wait_idle();

    // Backpressure: 8 back-to-back attempts, DEPTH+1 can be absorbed
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_op = bp_op[i]; cmd_a = bp_a[i]; cmd_b = bp_b[i];
      @(negedge clk);
      if (cmd_ready) begin
        accepted++;
        exp_q.push_back('{data: bp_d[i], flags: bp_f[i], err: bp_e[i]});
        $display("cmd op=%0h a=%02h b=%02h", bp_op[i], bp_a[i], bp_b[i]);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepted",  accepted,               32'd5);
    check("bp_cmd_ready", {31'd0, cmd_ready},     32'd0);
    rsp_ready = 1'b1;
    wait_idle();

    // Reset while a response is pending with three commands queued
    rsp_ready = 1'b0;
    send(4'd1, 8'hFF, 8'h0F, 8'h0F, 3'b100, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = rsp_valid;
    end
    check("midrst_reach_resp", {31'd0, seen}, 32'd1);
    send(4'd2, 8'h01, 8'h01, 8'h01, 3'b010, 1'b0);
    send(4'd3, 8'h01, 8'h02, 8'h03, 3'b001, 1'b0);
    send(4'd4, 8'h00, 8'h00, 8'hFF, 3'b010, 1'b0);
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_valid_after", {31'd0, rsp_valid}, 32'd0);
    check("midrst_busy_after",  {31'd0, busy},      32'd0);
    check("midrst_cmd_ready",   {31'd0, cmd_ready}, 32'd1);
    check("scoreboard_empty",   exp_q.size(),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
